// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: keeps up to Depth requests in flight and queues returned words in order.
// Optional FETCH_BYPASS_EN forwards a live response straight to decode when the queue is empty.
module fetch_prefetch #(
  parameter int unsigned     Xlen    = 32,
  parameter int unsigned     Ilen    = 32,
  parameter int unsigned     Depth   = 4,
  parameter logic [Xlen-1:0] ResetPc = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            control_hazard_i,
  input  logic [Xlen-1:0] pc_target_i,
  input  logic            mem_ready_i,
  output logic            mem_valid_o,
  output logic [Xlen-1:0] mem_addr_o,
  input  logic [Xlen-1:0] mem_rdata_i,
  input  logic            mem_rvalid_i,
  input  logic            inst_ready_i,
  output logic            inst_valid_o,
  output logic [Xlen-1:0] inst_pc_o,
  output logic [Ilen-1:0] inst_data_o
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(Depth);

  function automatic logic [Xlen-1:0] align_pc(input logic [Xlen-1:0] a);
    return {a[Xlen-1:2], 2'b00};
  endfunction

  logic [Xlen-1:0] pc_q, resp_pc_q;
  logic [CW-1:0]   occ_q, out_q, disc_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [Xlen-1:0] pc_mem [Depth];
  logic [Ilen-1:0] dat_mem [Depth];

  logic [CW:0] inflight;
  logic        issue, live, byp, wr_en, pop, occ_nz;

  assign inflight    = {1'b0, occ_q} + {1'b0, out_q};
  assign mem_valid_o = !rst_i && !control_hazard_i && (inflight < DEPTH_C);
  assign mem_addr_o  = pc_q;
  assign issue       = mem_valid_o && mem_ready_i;
  assign live        = mem_rvalid_i && (disc_q == '0) && !control_hazard_i;
  assign occ_nz      = (occ_q != '0);

`ifdef FETCH_BYPASS_EN
  assign byp = live && !occ_nz;
`else
  assign byp = 1'b0;
`endif

  // A bypassed response taken by decode this cycle never enters the queue.
  assign wr_en = live && !(byp && inst_ready_i);
  assign pop   = occ_nz && inst_ready_i && !control_hazard_i;

  assign inst_valid_o = occ_nz || byp;
  assign inst_pc_o    = occ_nz ? pc_mem[rd_ptr_q]  : (byp ? resp_pc_q : '0);
  assign inst_data_o  = occ_nz ? dat_mem[rd_ptr_q] : (byp ? mem_rdata_i[Ilen-1:0] : '0);

  // Control state: redirect overrides issue/response/pop bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= ResetPc;
      resp_pc_q <= ResetPc;
      occ_q     <= '0;
      out_q     <= '0;
      disc_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else if (control_hazard_i) begin
      pc_q      <= align_pc(pc_target_i);
      resp_pc_q <= align_pc(pc_target_i);
      occ_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      out_q     <= out_q - CW'(mem_rvalid_i);
      disc_q    <= out_q - CW'(mem_rvalid_i);
    end else begin
      if (issue) pc_q <= pc_q + Xlen'(4);
      if (live) resp_pc_q <= resp_pc_q + Xlen'(4);
      out_q <= out_q + CW'(issue) - CW'(mem_rvalid_i);
      if (mem_rvalid_i && !live && (disc_q != '0)) disc_q <= disc_q - CW'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      occ_q <= occ_q + CW'(wr_en) - CW'(pop);
    end
  end

  // Queue storage: data only, visibility is governed by occ_q.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]  <= resp_pc_q;
      dat_mem[wr_ptr_q] <= mem_rdata_i[Ilen-1:0];
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: cycle table after reset plus redirect, stall and backpressure sequences.
module tb_fetch_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        control_hazard_i = 1'b0;
  logic [31:0] pc_target_i = '0;
  logic        mem_ready_i = 1'b1;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic        inst_ready_i = 1'b1;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_data_o;

  fetch_prefetch #(.Xlen(32), .Ilen(32), .Depth(4), .ResetPc(32'h100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .control_hazard_i(control_hazard_i), .pc_target_i(pc_target_i),
    .mem_ready_i(mem_ready_i), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .inst_ready_i(inst_ready_i),
    .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o), .inst_data_o(inst_data_o)
  );

  always #5 clk_i = ~clk_i;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int lat    = 1;
  int nissue = 0;
  int ndel   = 0;
  logic [31:0] exp_issue, exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  typedef struct {
    logic        mv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] idat;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drives memory response for this cycle, then tracks issue and delivery.
  task automatic step_pre();
    logic [31:0] a;
    int d;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      d = pend_due.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(a);
    end
    #1;
    if (mem_valid_o && mem_ready_i) begin
      chk("issue_addr", mem_addr_o, exp_issue);
      exp_issue = exp_issue + 32'd4;
      pend_addr.push_back(mem_addr_o);
      pend_due.push_back(cyc + lat);
      nissue++;
    end
    if (control_hazard_i) begin
      exp_issue = {pc_target_i[31:2], 2'b00};
      exp_pc    = {pc_target_i[31:2], 2'b00};
    end else if (inst_valid_o && inst_ready_i) begin
      chk("inst_pc", inst_pc_o, exp_pc);
      chk("inst_data", inst_data_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ndel++;
    end
  endtask

  task automatic step_post();
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    control_hazard_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h100);
    chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_inst_data", inst_data_o, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc = 0;
    exp_issue = 32'h100;
    exp_pc = 32'h100;
  endtask

  task automatic run_until_delivery(input string name, input int budget);
    int start;
    start = ndel;
    for (int k = 0; k < budget; k++) begin
      if (ndel != start) break;
      step();
    end
    ntests++;
    if (ndel == start) begin
      nfail++;
      $display("FAIL %s: no delivery within %0d cycles", name, budget);
    end
  endtask

  initial begin
`ifdef FETCH_BYPASS_EN
    tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    tbl[1] = '{1'b1, 32'h104, 1'b1, 32'h100, mem_word(32'h100)};
    tbl[2] = '{1'b1, 32'h108, 1'b1, 32'h104, mem_word(32'h104)};
    tbl[3] = '{1'b1, 32'h10C, 1'b1, 32'h108, mem_word(32'h108)};
    tbl[4] = '{1'b1, 32'h110, 1'b1, 32'h10C, mem_word(32'h10C)};
`else
    tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    tbl[1] = '{1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
    tbl[2] = '{1'b1, 32'h108, 1'b1, 32'h100, mem_word(32'h100)};
    tbl[3] = '{1'b1, 32'h10C, 1'b1, 32'h104, mem_word(32'h104)};
    tbl[4] = '{1'b1, 32'h110, 1'b1, 32'h108, mem_word(32'h108)};
`endif
    @(negedge clk_i);

    // Streaming after reset: one-cycle memory, consumer always ready.
    lat = 1; inst_ready_i = 1'b1; mem_ready_i = 1'b1;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      step_pre();
      chk($sformatf("tbl%0d_mem_valid", i), {31'b0, mem_valid_o}, {31'b0, tbl[i].mv});
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_inst_valid", i), {31'b0, inst_valid_o}, {31'b0, tbl[i].iv});
      chk($sformatf("tbl%0d_inst_pc", i), inst_pc_o, tbl[i].ipc);
      chk($sformatf("tbl%0d_inst_data", i), inst_data_o, tbl[i].idat);
      step_post();
    end
    for (int i = 0; i < 10; i++) step();

    // Consumer stalled: exactly Depth requests, then issue stops until a pop.
    reset_dut();
    inst_ready_i = 1'b0;
    nissue = 0;
    for (int i = 0; i < 8; i++) step();
    chk("stall_issue_count", nissue, 32'd4);
    chk("stall_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("stall_occ", {29'b0, dut.occ_q}, 32'd4);
    chk("stall_head_pc", inst_pc_o, 32'h100);
    inst_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (mem_valid_o) break;
      step();
    end
    chk("resume_mem_valid", {31'b0, mem_valid_o}, 32'd1);
    chk("resume_mem_addr", mem_addr_o, 32'h110);
    for (int i = 0; i < 10; i++) step();

    // Redirect with three requests outstanding, latency 4.
    reset_dut();
    lat = 4;
    for (int i = 0; i < 3; i++) step();
    chk("redir_out_before", {29'b0, dut.out_q}, 32'd3);
    control_hazard_i = 1'b1; pc_target_i = 32'h2002;
    step();
    control_hazard_i = 1'b0;
    chk("redir_disc", {29'b0, dut.disc_q}, 32'd3);
    chk("redir_next_addr", mem_addr_o, 32'h2000);
    run_until_delivery("redir_delivery", 20);
    chk("redir_first_pc", exp_pc, 32'h2004);
    for (int i = 0; i < 6; i++) step();

    // Back-to-back redirects: second sees one response arriving.
    reset_dut();
    lat = 4;
    for (int i = 0; i < 3; i++) step();
    control_hazard_i = 1'b1; pc_target_i = 32'h2000;
    step();
    pc_target_i = 32'h4000;
    step();
    control_hazard_i = 1'b0;
    chk("b2b_disc", {29'b0, dut.disc_q}, 32'd2);
    run_until_delivery("b2b_delivery", 20);
    chk("b2b_first_pc", exp_pc, 32'h4004);

    // Redirect coincides with the only outstanding response.
    reset_dut();
    lat = 1;
    step();
    control_hazard_i = 1'b1; pc_target_i = 32'h3000;
    step();
    control_hazard_i = 1'b0;
    chk("same_cyc_disc", {29'b0, dut.disc_q}, 32'd0);
    chk("same_cyc_out", {29'b0, dut.out_q}, 32'd0);
    run_until_delivery("same_cyc_delivery", 10);
    chk("same_cyc_first_pc", exp_pc, 32'h3004);

    // Memory ready toggling 1,0,0,1 with latency 2.
    reset_dut();
    lat = 2;
    ndel = 0;
    for (int i = 0; i < 40; i++) begin
      mem_ready_i = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    mem_ready_i = 1'b1;
    ntests++;
    if (ndel < 10) begin
      nfail++;
      $display("FAIL stall_progress: got %0d deliveries, expected at least 10", ndel);
    end

    // Reset asserted mid-operation clears outputs immediately.
    for (int i = 0; i < 3; i++) step();
    reset_dut();
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
